// File: rtl/beam_thresh_loader_pkg.sv
// Shared types and constants for the beam threshold loader, the upstream
// threshold writer and the downstream trigger comparators.
package beam_thresh_pkg;

  localparam int unsigned TWIDTH_DEF = 18;

  // Lane 0 of the threshold bus carries even beam 2k, lane 1 carries odd beam 2k+1.
  localparam int unsigned LANE_EVEN = 0;
  localparam int unsigned LANE_ODD  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2,
    ST_ERR  = 2'd3
  } ld_state_e;

  function automatic int unsigned ndual(input int unsigned nbeams);
    return (nbeams + 1) / 2;
  endfunction

  function automatic int unsigned idx_width(input int unsigned nd);
    return (nd > 1) ? $clog2(nd) : 1;
  endfunction

endpackage

// File: rtl/beam_thresh_loader_if.sv
// Serial dual-lane threshold write stream from the WISHBONE threshold block.
interface beam_thresh_loader_if import beam_thresh_pkg::*; #(
    parameter int unsigned TWIDTH = TWIDTH_DEF
);
    logic [2*TWIDTH-1:0] thresh_i;
    logic [1:0]          thresh_wr_i;
    logic [1:0]          thresh_update_i;

    modport master (output thresh_i, output thresh_wr_i, output thresh_update_i);
    modport slave  (input  thresh_i, input  thresh_wr_i, input  thresh_update_i);
endinterface

// File: rtl/beam_thresh_loader_cursor.sv
// Write cursor: pair index counting down from NDUAL-1 plus a delta/trig half bit.
// last_o flags the slot whose write completes the whole set.
module beam_thresh_cursor import beam_thresh_pkg::*; #(
    parameter  int unsigned NDUAL = 23,
    localparam int unsigned IW    = idx_width(NDUAL)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          step_i,
    input  logic          clear_i,
    output logic [IW-1:0] idx_o,
    output logic          half_o,
    output logic          last_o
);
    localparam logic [IW-1:0] IDX_START = IW'(NDUAL - 1);

    logic [IW-1:0] idx_q, idx_d;
    logic          half_q, half_d;

    assign last_o = (idx_q == '0) && half_q;
    assign idx_o  = idx_q;
    assign half_o = half_q;

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch can form.
        idx_d  = idx_q;
        half_d = half_q;
        if (clear_i || (step_i && last_o)) begin
            idx_d  = IDX_START;
            half_d = 1'b0;
        end else if (step_i) begin
            half_d = ~half_q;
            if (half_q) idx_d = idx_q - IW'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!aresetn) begin
            idx_q  <= IDX_START;
            half_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            half_q <= half_d;
        end
    end
endmodule

// File: rtl/beam_thresh_loader.sv
// Assembles the dual-lane threshold stream into per-beam shadow registers and
// commits them atomically on update. Optional BEAM_THRESH_LOADER_STATS_EN adds counters.
module beam_thresh_loader import beam_thresh_pkg::*; #(
    parameter int unsigned       NBEAMS      = 46,
    parameter int unsigned       TWIDTH      = TWIDTH_DEF,
    parameter logic [TWIDTH-1:0] RESET_TRIG  = 18'h3FFFF,
    parameter logic [TWIDTH-1:0] RESET_DELTA = 18'h00000
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    beam_thresh_loader_if.slave      wr_if,
    output logic [NBEAMS*TWIDTH-1:0] trig_thresh_o,
    output logic [NBEAMS*TWIDTH-1:0] delta_thresh_o,
    output logic                     thresh_valid_o,
    output logic                     commit_o,
    output logic                     load_err_o
`ifdef BEAM_THRESH_LOADER_STATS_EN
    ,
    output logic [15:0]              commit_count_o,
    output logic [15:0]              err_count_o
`endif
);
    localparam int unsigned NDUAL = ndual(NBEAMS);
    localparam int unsigned IW    = idx_width(NDUAL);

    logic [TWIDTH-1:0] lane0, lane1;
    logic              wr_stb, upd_stb, lane_mis;

    assign lane0    = wr_if.thresh_i[LANE_EVEN*TWIDTH +: TWIDTH];
    assign lane1    = wr_if.thresh_i[LANE_ODD*TWIDTH +: TWIDTH];
    assign wr_stb   = wr_if.thresh_wr_i[0];
    assign upd_stb  = wr_if.thresh_update_i[0];
    assign lane_mis = (wr_if.thresh_wr_i[0] ^ wr_if.thresh_wr_i[1]) |
                      (wr_if.thresh_update_i[0] ^ wr_if.thresh_update_i[1]);

    logic [IW-1:0] idx;
    logic          half, last, step, clear;

    beam_thresh_cursor #(.NDUAL(NDUAL)) u_cursor (
        .aclk    (aclk),
        .aresetn (aresetn),
        .step_i  (step),
        .clear_i (clear),
        .idx_o   (idx),
        .half_o  (half),
        .last_o  (last)
    );

    ld_state_e state_q, state_d;
    logic      do_commit, do_err;
    logic      commit_q, err_q, valid_q;

    always_comb begin
        state_d   = state_q;
        step      = 1'b0;
        clear     = 1'b0;
        do_commit = 1'b0;
        do_err    = 1'b0;
        if (lane_mis) begin
            state_d = ST_ERR;
            clear   = 1'b1;
            do_err  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: if (wr_stb && !upd_stb) begin
                    step    = 1'b1;
                    state_d = ST_LOAD;
                end
                ST_LOAD: if (upd_stb) begin
                    // A write that completes the set commits alongside the update.
                    if (wr_stb && last) begin
                        step      = 1'b1;
                        do_commit = 1'b1;
                    end else begin
                        clear  = 1'b1;
                        do_err = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (wr_stb) begin
                    step = 1'b1;
                    if (last) state_d = ST_FULL;
                end
                ST_FULL: if (upd_stb) begin
                    do_commit = 1'b1;
                    clear     = 1'b1;
                    state_d   = ST_IDLE;
                end else if (wr_stb) begin
                    state_d = ST_ERR;
                end
                ST_ERR: if (upd_stb) begin
                    do_err  = 1'b1;
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            commit_q <= do_commit;
            err_q    <= do_err;
            if (do_commit) valid_q <= 1'b1;
        end
    end

    // Shadow next-state doubles as the commit source so the final pair bypasses the register.
    logic [TWIDTH-1:0] sh_trig_q  [NBEAMS];
    logic [TWIDTH-1:0] sh_delta_q [NBEAMS];
    logic [TWIDTH-1:0] sh_trig_d  [NBEAMS];
    logic [TWIDTH-1:0] sh_delta_d [NBEAMS];
    logic [TWIDTH-1:0] act_trig_q [NBEAMS];
    logic [TWIDTH-1:0] act_delta_q[NBEAMS];
    logic [31:0]       beam_lo;

    assign beam_lo = {{(31-IW){1'b0}}, idx, 1'b0};

    always_comb begin
        for (int unsigned b = 0; b < NBEAMS; b++) begin
            sh_trig_d[b]  = sh_trig_q[b];
            sh_delta_d[b] = sh_delta_q[b];
            if (step && (b == beam_lo || b == beam_lo + 1)) begin
                if (half) sh_trig_d[b]  = (b == beam_lo) ? lane0 : lane1;
                else      sh_delta_d[b] = (b == beam_lo) ? lane0 : lane1;
            end
        end
    end

    // NOTE: shadow storage has no reset; only a complete load can reach the active set.
    always_ff @(posedge aclk) begin
        sh_trig_q  <= sh_trig_d;
        sh_delta_q <= sh_delta_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned b = 0; b < NBEAMS; b++) begin
                act_trig_q[b]  <= RESET_TRIG;
                act_delta_q[b] <= RESET_DELTA;
            end
        end else if (do_commit) begin
            act_trig_q  <= sh_trig_d;
            act_delta_q <= sh_delta_d;
        end
    end

    for (genvar b = 0; b < NBEAMS; b++) begin : g_pack
        assign trig_thresh_o[b*TWIDTH +: TWIDTH]  = act_trig_q[b];
        assign delta_thresh_o[b*TWIDTH +: TWIDTH] = act_delta_q[b];
    end

    assign thresh_valid_o = valid_q;
    assign commit_o       = commit_q;
    assign load_err_o     = err_q;

`ifdef BEAM_THRESH_LOADER_STATS_EN
    logic [15:0] commit_cnt_q, err_cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            commit_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            if (do_commit && commit_cnt_q != '1) commit_cnt_q <= commit_cnt_q + 16'd1;
            if (do_err && err_cnt_q != '1)       err_cnt_q    <= err_cnt_q + 16'd1;
        end
    end

    assign commit_count_o = commit_cnt_q;
    assign err_count_o    = err_cnt_q;
`endif
endmodule

// File: tb/tb_beam_thresh_loader.sv
// Scoreboard bench: one stream drives a 46-beam and a 45-beam loader; a load-level
// reference model queues expected commit/error pulses, monitors pop and compare.
module tb_beam_thresh_loader;
    import beam_thresh_pkg::*;

    localparam int TW    = 18;
    localparam int NB0   = 46;
    localparam int NB1   = 45;
    localparam int NDUAL = 23;
    localparam int NW    = 2 * NDUAL;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    beam_thresh_loader_if #(.TWIDTH(TW)) if_a ();
    beam_thresh_loader_if #(.TWIDTH(TW)) if_b ();

    logic [NB0*TW-1:0] trig_a, delta_a;
    logic [NB1*TW-1:0] trig_b, delta_b;
    logic              valid_a, commit_a, err_a, valid_b, commit_b, err_b;

    beam_thresh_loader #(.NBEAMS(NB0), .TWIDTH(TW), .RESET_TRIG(18'h3FFFF), .RESET_DELTA(18'h0)) dut_a (
        .aclk(aclk), .aresetn(aresetn), .wr_if(if_a),
        .trig_thresh_o(trig_a), .delta_thresh_o(delta_a),
        .thresh_valid_o(valid_a), .commit_o(commit_a), .load_err_o(err_a));

    beam_thresh_loader #(.NBEAMS(NB1), .TWIDTH(TW), .RESET_TRIG(18'h3FFFF), .RESET_DELTA(18'h0)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .wr_if(if_b),
        .trig_thresh_o(trig_b), .delta_thresh_o(delta_b),
        .thresh_valid_o(valid_b), .commit_o(commit_b), .load_err_o(err_b));

    typedef struct packed {
        logic              is_commit;
        logic              valid;
        logic [NB0*TW-1:0] trig;
        logic [NB0*TW-1:0] delta;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference state: shadow and active sets per instance, load progress shared.
    logic [TW-1:0] sh_t[2][NB0];
    logic [TW-1:0] sh_d[2][NB0];
    logic [TW-1:0] ac_t[2][NB0];
    logic [TW-1:0] ac_d[2][NB0];
    bit            m_valid[2];
    int            m_cnt;
    bit            m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int nbeams(input int d);
        return (d == 0) ? NB0 : NB1;
    endfunction

    task automatic snap(input int d, output ev_t ev);
        ev       = '0;
        ev.valid = m_valid[d];
        for (int b = 0; b < nbeams(d); b++) begin
            ev.trig[b*TW +: TW]  = ac_t[d][b];
            ev.delta[b*TW +: TW] = ac_d[d][b];
        end
    endtask

    task automatic push_ev(input int d, input bit is_commit);
        ev_t ev;
        snap(d, ev);
        ev.is_commit = is_commit;
        if (d == 0) q_a.push_back(ev);
        else        q_b.push_back(ev);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < NB0; b++) begin
                ac_t[d][b] = 18'h3FFFF;
                ac_d[d][b] = 18'h0;
            end
            m_valid[d] = 1'b0;
        end
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    // Write w of a load lands in pair NDUAL-1-w/2; even w is delta, odd w is trig.
    task automatic model_store(input int w, input logic [2*TW-1:0] data);
        int p;
        p = NDUAL - 1 - w / 2;
        for (int d = 0; d < 2; d++) begin
            for (int lane = 0; lane < 2; lane++) begin
                if (2*p + lane < nbeams(d)) begin
                    if (w % 2 == 1) sh_t[d][2*p + lane] = data[lane*TW +: TW];
                    else            sh_d[d][2*p + lane] = data[lane*TW +: TW];
                end
            end
        end
    endtask

    task automatic model_commit();
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < nbeams(d); b++) begin
                ac_t[d][b] = sh_t[d][b];
                ac_d[d][b] = sh_d[d][b];
            end
            m_valid[d] = 1'b1;
            push_ev(d, 1'b1);
        end
    endtask

    task automatic model_err();
        push_ev(0, 1'b0);
        push_ev(1, 1'b0);
    endtask

    task automatic model_apply(input logic [1:0] wr, input logic [1:0] upd, input logic [2*TW-1:0] data);
        if (wr[0] != wr[1] || upd[0] != upd[1]) begin
            m_err = 1'b1;
            m_cnt = 0;
            model_err();
            return;
        end
        if (m_err) begin
            if (upd[0]) begin
                m_err = 1'b0;
                model_err();
            end
            return;
        end
        if (upd[0]) begin
            if (wr[0] && m_cnt == NW - 1) begin
                model_store(m_cnt, data);
                m_cnt++;
            end
            if (m_cnt == NW)    model_commit();
            else if (m_cnt > 0) model_err();
            m_cnt = 0;
            return;
        end
        if (wr[0]) begin
            if (m_cnt == NW) begin
                m_err = 1'b1;
                m_cnt = 0;
            end else begin
                model_store(m_cnt, data);
                m_cnt++;
            end
        end
    endtask

    function automatic logic [2*TW-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[2*TW-1:0];
    endfunction

    task automatic drive(input logic [1:0] wr, input logic [1:0] upd, input logic [2*TW-1:0] data);
        @(negedge aclk);
        if_a.thresh_i        = data;
        if_a.thresh_wr_i     = wr;
        if_a.thresh_update_i = upd;
        if_b.thresh_i        = data;
        if_b.thresh_wr_i     = wr;
        if_b.thresh_update_i = upd;
        model_apply(wr, upd, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 2'b00, rnd_data());
    endtask

    // pattern: pair p delta lanes {1000+2p+1, 1000+2p}, trig lanes {2000+2p+1, 2000+2p}.
    task automatic load(input int nwr, input bit pattern, input bit same_cycle);
        logic [TW-1:0]   l0, l1;
        logic [2*TW-1:0] data;
        int              p, base;
        for (int w = 0; w < nwr; w++) begin
            if ($urandom_range(3) == 0) idle(1);
            if (pattern) begin
                p    = NDUAL - 1 - w / 2;
                base = (w % 2 == 1) ? 2000 : 1000;
                l0   = TW'(base + 2*p);
                l1   = TW'(base + 2*p + 1);
                data = {l1, l0};
            end else begin
                data = rnd_data();
            end
            if (same_cycle && w == nwr - 1) drive(2'b11, 2'b11, data);
            else                            drive(2'b11, 2'b00, data);
        end
        if (!same_cycle) begin
            if ($urandom_range(1) == 0) idle($urandom_range(3, 1));
            drive(2'b00, 2'b11, rnd_data());
        end
        idle(2);
    endtask

    task automatic cmp_beams(input string tag, input int d,
                             input logic [NB0*TW-1:0] t, input logic [NB0*TW-1:0] dl,
                             input logic [NB0*TW-1:0] et, input logic [NB0*TW-1:0] ed);
        int bt, bd;
        bt = -1;
        bd = -1;
        for (int b = 0; b < nbeams(d); b++) begin
            if (bt < 0 && t[b*TW +: TW] !== et[b*TW +: TW]) bt = b;
            if (bd < 0 && dl[b*TW +: TW] !== ed[b*TW +: TW]) bd = b;
        end
        if (bt < 0) bt = 0;
        if (bd < 0) bd = 0;
        check($sformatf("%s trig beam %0d", tag, bt), t[bt*TW +: TW], et[bt*TW +: TW]);
        check($sformatf("%s delta beam %0d", tag, bd), dl[bd*TW +: TW], ed[bd*TW +: TW]);
    endtask

    task automatic mon_cmp(input int d, input logic c, input logic e, input logic v,
                           input logic [NB0*TW-1:0] t, input logic [NB0*TW-1:0] dl);
        ev_t   ex;
        string tag;
        tag = (d == 0) ? "nb46" : "nb45";
        if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
            check({tag, " unexpected pulse {commit,err}"}, {c, e}, 2'b00);
            return;
        end
        ex = (d == 0) ? q_a.pop_front() : q_b.pop_front();
        check({tag, " pulse {commit,err}"}, {c, e}, ex.is_commit ? 2'b10 : 2'b01);
        check({tag, " thresh_valid"}, v, ex.valid);
        cmp_beams(tag, d, t, dl, ex.trig, ex.delta);
    endtask

    always @(negedge aclk) begin
        if (aresetn) begin
            if (commit_a || err_a) mon_cmp(0, commit_a, err_a, valid_a, trig_a, delta_a);
            if (commit_b || err_b) mon_cmp(1, commit_b, err_b, valid_b, {{TW{1'b0}}, trig_b}, {{TW{1'b0}}, delta_b});
        end
    end

    // Quiescent comparison of both instances against the reference active set.
    task automatic check_state(input string tag);
        ev_t ea, eb;
        snap(0, ea);
        snap(1, eb);
        check({tag, " nb46 valid"}, valid_a, ea.valid);
        check({tag, " nb45 valid"}, valid_b, eb.valid);
        check({tag, " pulses idle"}, {commit_a, err_a, commit_b, err_b}, 4'b0000);
        cmp_beams({tag, " nb46"}, 0, trig_a, delta_a, ea.trig, ea.delta);
        cmp_beams({tag, " nb45"}, 1, {{TW{1'b0}}, trig_b}, {{TW{1'b0}}, delta_b}, eb.trig, eb.delta);
    endtask

    initial begin
        if_a.thresh_i = '0; if_a.thresh_wr_i = '0; if_a.thresh_update_i = '0;
        if_b.thresh_i = '0; if_b.thresh_wr_i = '0; if_b.thresh_update_i = '0;
        model_reset();
        repeat (3) @(negedge aclk);
        check_state("reset");
        aresetn = 1'b1;

        // Test-plan load with known values, then direct spot checks.
        load(NW, 1'b1, 1'b0);
        check("nb46 trig beam 0",   trig_a[0*TW +: TW],   18'd2000);
        check("nb46 trig beam 7",   trig_a[7*TW +: TW],   18'd2007);
        check("nb46 delta beam 45", delta_a[45*TW +: TW], 18'd1045);
        check("nb45 trig beam 44",  trig_b[44*TW +: TW],  18'd2044);
        check("nb45 delta beam 44", delta_b[44*TW +: TW], 18'd1044);
        check("nb45 delta beam 43", delta_b[43*TW +: TW], 18'd1043);

        drive(2'b00, 2'b11, rnd_data());   // update with nothing loaded
        idle(2);

        load(20, 1'b0, 1'b0);              // partial -> error, previous set kept
        load(NW, 1'b0, 1'b1);              // final write coincides with update
        load(NW + 1, 1'b0, 1'b0);          // overflow

        for (int w = 0; w < 10; w++) drive(2'b11, 2'b00, rnd_data());
        drive(2'b01, 2'b00, rnd_data());   // write lane mismatch
        for (int w = 0; w < 5; w++) drive(2'b11, 2'b00, rnd_data());
        drive(2'b00, 2'b11, rnd_data());
        idle(2);
        drive(2'b00, 2'b10, rnd_data());   // update lane mismatch from idle
        drive(2'b00, 2'b11, rnd_data());
        idle(2);
        load(NW, 1'b0, 1'b0);

        // Reset at write 30 discards the partial load and restores reset values.
        for (int w = 0; w < 30; w++) drive(2'b11, 2'b00, rnd_data());
        @(negedge aclk);
        aresetn = 1'b0;
        if_a.thresh_wr_i = '0; if_a.thresh_update_i = '0;
        if_b.thresh_wr_i = '0; if_b.thresh_update_i = '0;
        model_reset();
        repeat (2) @(negedge aclk);
        check_state("mid-load reset");
        aresetn = 1'b1;
        load(NW, 1'b1, 1'b0);

        for (int it = 0; it < 25; it++) begin
            int unsigned r;
            r = $urandom_range(9);
            if (r <= 5)      load(NW, 1'b0, bit'($urandom_range(1)));
            else if (r == 6) load(int'($urandom_range(45, 1)), 1'b0, bit'($urandom_range(1)));
            else if (r == 7) load(int'($urandom_range(49, 47)), 1'b0, 1'b0);
            else if (r == 8) begin
                for (int w = 0; w < int'($urandom_range(20)); w++) drive(2'b11, 2'b00, rnd_data());
                drive(2'b10, 2'b00, rnd_data());
                drive(2'b00, 2'b11, rnd_data());
                idle(2);
            end else begin
                drive(2'b00, 2'b11, rnd_data());
                idle(1);
            end
        end

        idle(4);
        check_state("final");
        check("nb46 pending expected pulses", 64'(q_a.size()), 64'd0);
        check("nb45 pending expected pulses", 64'(q_b.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
